// File: rtl/branch_predictor_if.sv
// Fetch/execute <-> predictor bundle: lookup and resolve ports.
// master = pipeline side, slave = predictor side.
interface branch_predictor_if #(
  parameter int ADDR_W = 32,
  parameter int HIST_W = 2
);
  logic              lk_valid;
  logic [ADDR_W-1:0] lk_pc;
  logic              lk_taken;
  logic [ADDR_W-1:0] lk_target;
  logic [HIST_W-1:0] lk_hist;
  logic              up_valid;
  logic [ADDR_W-1:0] up_pc;
  logic [HIST_W-1:0] up_hist;
  logic              up_taken;
  logic [ADDR_W-1:0] up_target;
  logic              up_mispred;

  modport master (
    output lk_valid, lk_pc,
    input  lk_taken, lk_target, lk_hist,
    output up_valid, up_pc, up_hist,
    output up_taken, up_target, up_mispred
  );

  modport slave (
    input  lk_valid, lk_pc,
    output lk_taken, lk_target, lk_hist,
    input  up_valid, up_pc, up_hist,
    input  up_taken, up_target, up_mispred
  );
endinterface

// File: rtl/branch_predictor.sv
// Two-level predictor: GHR + PHT of saturating counters + tagged BTB.
// Ports: clk, rstn, ready, bp (lookup/update bundle), stat_* counters.
module branch_predictor #(
  parameter int ADDR_W   = 32,
  parameter int INDEX_W  = 8,
  parameter int HIST_W   = 2,
  parameter int CTR_W    = 2,
  parameter int CTR_INIT = 1,
  parameter int MODE     = 0
) (
  input  logic        clk,
  input  logic        rstn,
  output logic        ready,
  branch_predictor_if.slave bp,
  output logic [31:0] stat_total,
  output logic [31:0] stat_correct,
  output logic [31:0] stat_mispred
);
  localparam int PHT_W = INDEX_W + HIST_W;
  localparam int PHT_N = 1 << PHT_W;
  localparam int BTB_N = 1 << INDEX_W;
  localparam int TAG_W = ADDR_W - INDEX_W;

  typedef enum logic {S_INIT, S_RUN} state_e;

  state_e            state_q, state_d;
  logic [PHT_W-1:0]  ptr_q, ptr_d;
  logic [HIST_W-1:0] ghr_q, ghr_d;
  logic [31:0]       tot_q, tot_d;
  logic [31:0]       cor_q, cor_d;
  logic [31:0]       mis_q, mis_d;

  logic [CTR_W-1:0]  pht_q [PHT_N];
  logic              btb_v_q [BTB_N];
  logic [TAG_W-1:0]  btb_tag_q [BTB_N];
  logic [ADDR_W-1:0] btb_tgt_q [BTB_N];

  logic              run;
  logic [PHT_W-1:0]  lk_idx, up_idx, pht_wa;
  logic [INDEX_W-1:0] lk_bidx, up_bidx, clr_idx;
  logic              lk_hit;
  logic              up_en;
  logic [CTR_W-1:0]  up_ctr, ctr_nxt, pht_wd;
  logic              pht_we, btb_we, btb_clr;

  function automatic logic [PHT_W-1:0] pht_idx(
    input logic [ADDR_W-1:0] pc,
    input logic [HIST_W-1:0] h
  );
    if (MODE == 1)
      return pc[PHT_W-1:0] ^ {{INDEX_W{1'b0}}, h};
    return {pc[INDEX_W-1:0], h};
  endfunction

  assign run   = (state_q == S_RUN);
  assign ready = run;

  assign stat_total   = tot_q;
  assign stat_correct = cor_q;
  assign stat_mispred = mis_q;

  // Lookup: zero-latency, sees pre-edge table contents.
  always_comb begin
    lk_idx  = pht_idx(bp.lk_pc, ghr_q);
    lk_bidx = bp.lk_pc[INDEX_W-1:0];
    lk_hit  = btb_v_q[lk_bidx] &&
              (btb_tag_q[lk_bidx] == bp.lk_pc[ADDR_W-1:INDEX_W]);
    bp.lk_taken  = run && pht_q[lk_idx][CTR_W-1] && lk_hit;
    bp.lk_target = bp.lk_taken ? btb_tgt_q[lk_bidx]
                               : bp.lk_pc + ADDR_W'(1);
    bp.lk_hist   = ghr_q;
  end

  always_comb begin
    up_en   = run && bp.up_valid;
    up_idx  = pht_idx(bp.up_pc, bp.up_hist);
    up_bidx = bp.up_pc[INDEX_W-1:0];
    up_ctr  = pht_q[up_idx];
    ctr_nxt = up_ctr;
    if (bp.up_taken) begin
      if (up_ctr != {CTR_W{1'b1}}) ctr_nxt = up_ctr + CTR_W'(1);
    end else begin
      if (up_ctr != '0) ctr_nxt = up_ctr - CTR_W'(1);
    end
    clr_idx = ptr_q[INDEX_W-1:0];
    btb_clr = !run && (ptr_q[PHT_W-1:INDEX_W] == '0);
    btb_we  = up_en && bp.up_taken;
    if (run) begin
      pht_we = up_en;
      pht_wa = up_idx;
      pht_wd = ctr_nxt;
    end else begin
      pht_we = 1'b1;
      pht_wa = ptr_q;
      pht_wd = CTR_W'(CTR_INIT);
    end
  end

  // FSM, GHR and statistics.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    ghr_d   = ghr_q;
    tot_d   = tot_q;
    cor_d   = cor_q;
    mis_d   = mis_q;
    unique case (state_q)
      S_INIT: begin
        ptr_d = ptr_q + PHT_W'(1);
        if (ptr_q == {PHT_W{1'b1}}) state_d = S_RUN;
      end
      S_RUN: begin
        // Recovery wins over a same-cycle speculative shift.
        if (up_en && bp.up_mispred)
          ghr_d = (bp.up_hist << 1) | HIST_W'(bp.up_taken);
        else if (bp.lk_valid)
          ghr_d = (ghr_q << 1) | HIST_W'(bp.lk_taken);
        if (up_en) begin
          tot_d = tot_q + 32'd1;
          if (bp.up_mispred) mis_d = mis_q + 32'd1;
          else               cor_d = cor_q + 32'd1;
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_INIT;
      ptr_q   <= '0;
      ghr_q   <= '0;
      tot_q   <= '0;
      cor_q   <= '0;
      mis_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ghr_q   <= ghr_d;
      tot_q   <= tot_d;
      cor_q   <= cor_d;
      mis_q   <= mis_d;
    end
  end

  // Tables carry no reset; the init sweep establishes them.
  always_ff @(posedge clk) begin
    if (pht_we) pht_q[pht_wa] <= pht_wd;
    if (btb_clr) btb_v_q[clr_idx] <= 1'b0;
    if (btb_we) begin
      btb_v_q[up_bidx]   <= 1'b1;
      btb_tag_q[up_bidx] <= bp.up_pc[ADDR_W-1:INDEX_W];
      btb_tgt_q[up_bidx] <= bp.up_target;
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench: concat-mode and gshare-mode predictors.
// Scenario tasks check inline against hand-computed values.
module tb_branch_predictor;
  logic clk = 1'b0;
  logic rstn0 = 1'b0;
  logic rstn1 = 1'b0;
  logic ready0, ready1;
  logic [31:0] tot0, cor0, mis0;
  logic [31:0] tot1, cor1, mis1;
  int total_n = 0;
  int bad_n = 0;

  always #5 clk = ~clk;

  branch_predictor_if #(.ADDR_W(32), .HIST_W(2)) b0 ();
  branch_predictor_if #(.ADDR_W(32), .HIST_W(2)) b1 ();

  branch_predictor #(.MODE(0)) dut0 (
    .clk(clk), .rstn(rstn0), .ready(ready0), .bp(b0),
    .stat_total(tot0), .stat_correct(cor0),
    .stat_mispred(mis0)
  );

  branch_predictor #(.MODE(1)) dut1 (
    .clk(clk), .rstn(rstn1), .ready(ready1), .bp(b1),
    .stat_total(tot1), .stat_correct(cor1),
    .stat_mispred(mis1)
  );

  task automatic upd0(input logic [31:0] pc, input logic [1:0] h,
                      input logic tk, input logic [31:0] tg,
                      input logic mis);
    b0.up_pc = pc; b0.up_hist = h; b0.up_taken = tk;
    b0.up_target = tg; b0.up_mispred = mis; b0.up_valid = 1'b1;
    @(posedge clk); #1;
    b0.up_valid = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    b0.lk_pc = 32'h123;
    #1;
    total_n++;
    if (ready0 !== 1'b0 || tot0 !== 0 || cor0 !== 0 || mis0 !== 0) begin
      bad_n++;
      $display("FAIL reset_state ready=%b tot=%0d cor=%0d mis=%0d want 0",
               ready0, tot0, cor0, mis0);
    end
    total_n++;
    if (b0.lk_hist !== 2'b00) begin
      bad_n++;
      $display("FAIL reset_ghr got=%b want=00", b0.lk_hist);
    end
    @(negedge clk);
    rstn0 = 1'b1;
    rstn1 = 1'b1;
    n = 0;
    while (n < 2000) begin
      @(posedge clk); #1;
      n++;
      if (n == 5) begin
        total_n++;
        if (b0.lk_taken !== 1'b0 || b0.lk_target !== 32'h124) begin
          bad_n++;
          $display("FAIL init_lookup taken=%b tgt=%h want 0/124",
                   b0.lk_taken, b0.lk_target);
        end
      end
      if (n == 10) begin
        b0.up_pc = 32'h40; b0.up_hist = 2'b00; b0.up_taken = 1'b1;
        b0.up_target = 32'h10; b0.up_mispred = 1'b1;
        b0.up_valid = 1'b1; b0.lk_valid = 1'b1;
      end
      if (n == 11) begin
        b0.up_valid = 1'b0; b0.lk_valid = 1'b0;
      end
      if (ready0 === 1'b1) break;
    end
    total_n++;
    if (n !== 1024) begin
      bad_n++;
      $display("FAIL init_length got=%0d want=1024", n);
    end
    total_n++;
    if (tot0 !== 0 || b0.lk_hist !== 2'b00) begin
      bad_n++;
      $display("FAIL init_ignore tot=%0d ghr=%b want 0/00", tot0, b0.lk_hist);
    end
  endtask

  task automatic test_training();
    upd0(32'h40, 2'b00, 1'b1, 32'h10, 1'b1);
    upd0(32'h40, 2'b00, 1'b1, 32'h10, 1'b1);
    total_n++;
    if (tot0 !== 2 || mis0 !== 2 || cor0 !== 0) begin
      bad_n++;
      $display("FAIL train_stats tot=%0d mis=%0d cor=%0d want 2/2/0",
               tot0, mis0, cor0);
    end
    total_n++;
    if (b0.lk_hist !== 2'b01) begin
      bad_n++;
      $display("FAIL train_recover got=%b want=01", b0.lk_hist);
    end
    upd0(32'h80, 2'b00, 1'b0, 32'h0, 1'b1);
    b0.lk_pc = 32'h40;
    #1;
    total_n++;
    if (b0.lk_taken !== 1'b1 || b0.lk_target !== 32'h10 ||
        b0.lk_hist !== 2'b00) begin
      bad_n++;
      $display("FAIL train_hit taken=%b tgt=%h hist=%b want 1/10/00",
               b0.lk_taken, b0.lk_target, b0.lk_hist);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 5; i++) upd0(32'h41, 2'b00, 1'b1, 32'h55, 1'b0);
    b0.lk_pc = 32'h41; #1;
    total_n++;
    if (b0.lk_taken !== 1'b1 || b0.lk_target !== 32'h55) begin
      bad_n++;
      $display("FAIL sat_high taken=%b tgt=%h want 1/55",
               b0.lk_taken, b0.lk_target);
    end
    upd0(32'h41, 2'b00, 1'b0, 32'h0, 1'b0);
    total_n++;
    if (b0.lk_taken !== 1'b1) begin
      bad_n++;
      $display("FAIL sat_one_nt taken=%b want 1", b0.lk_taken);
    end
    upd0(32'h41, 2'b00, 1'b0, 32'h0, 1'b0);
    total_n++;
    if (b0.lk_taken !== 1'b0 || b0.lk_target !== 32'h42) begin
      bad_n++;
      $display("FAIL sat_two_nt taken=%b tgt=%h want 0/42",
               b0.lk_taken, b0.lk_target);
    end
    upd0(32'h80, 2'b00, 1'b0, 32'h0, 1'b0);
    upd0(32'h80, 2'b00, 1'b1, 32'h99, 1'b0);
    b0.lk_pc = 32'h80; #1;
    total_n++;
    if (b0.lk_taken !== 1'b0) begin
      bad_n++;
      $display("FAIL sat_low taken=%b want 0", b0.lk_taken);
    end
    upd0(32'h80, 2'b00, 1'b1, 32'h99, 1'b0);
    total_n++;
    if (b0.lk_taken !== 1'b1 || b0.lk_target !== 32'h99) begin
      bad_n++;
      $display("FAIL sat_low_up taken=%b tgt=%h want 1/99",
               b0.lk_taken, b0.lk_target);
    end
    total_n++;
    if (tot0 !== 13 || cor0 !== 10 || mis0 !== 3) begin
      bad_n++;
      $display("FAIL sat_stats tot=%0d cor=%0d mis=%0d want 13/10/3",
               tot0, cor0, mis0);
    end
  endtask

  task automatic test_tag_alias();
    b0.lk_pc = 32'h140; #1;
    total_n++;
    if (b0.lk_taken !== 1'b0 || b0.lk_target !== 32'h141) begin
      bad_n++;
      $display("FAIL tag_alias taken=%b tgt=%h want 0/141",
               b0.lk_taken, b0.lk_target);
    end
  endtask

  task automatic test_same_cycle();
    b0.lk_pc = 32'h41;
    b0.up_pc = 32'h41; b0.up_hist = 2'b00; b0.up_taken = 1'b1;
    b0.up_target = 32'h55; b0.up_mispred = 1'b0; b0.up_valid = 1'b1;
    #1;
    total_n++;
    if (b0.lk_taken !== 1'b0) begin
      bad_n++;
      $display("FAIL same_cycle_pre taken=%b want 0", b0.lk_taken);
    end
    @(posedge clk); #1;
    b0.up_valid = 1'b0;
    total_n++;
    if (b0.lk_taken !== 1'b1) begin
      bad_n++;
      $display("FAIL same_cycle_post taken=%b want 1", b0.lk_taken);
    end
  endtask

  task automatic test_back_to_back();
    b0.up_pc = 32'h42; b0.up_hist = 2'b00; b0.up_target = 32'h66;
    b0.up_mispred = 1'b0; b0.up_taken = 1'b1; b0.up_valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    b0.up_taken = 1'b0;
    @(posedge clk); #1;
    b0.up_valid = 1'b0;
    b0.lk_pc = 32'h42; #1;
    total_n++;
    if (b0.lk_taken !== 1'b1 || b0.lk_target !== 32'h66) begin
      bad_n++;
      $display("FAIL back_to_back taken=%b tgt=%h want 1/66",
               b0.lk_taken, b0.lk_target);
    end
  endtask

  task automatic test_recovery();
    upd0(32'h90, 2'b01, 1'b1, 32'h91, 1'b1);
    total_n++;
    if (b0.lk_hist !== 2'b11) begin
      bad_n++;
      $display("FAIL recov_setup got=%b want=11", b0.lk_hist);
    end
    b0.lk_pc = 32'h33; b0.lk_valid = 1'b1;
    upd0(32'h90, 2'b01, 1'b0, 32'h0, 1'b1);
    total_n++;
    if (b0.lk_hist !== 2'b10) begin
      bad_n++;
      $display("FAIL recov_override got=%b want=10", b0.lk_hist);
    end
    @(posedge clk); #1;
    b0.lk_valid = 1'b0;
    total_n++;
    if (b0.lk_hist !== 2'b00) begin
      bad_n++;
      $display("FAIL spec_shift got=%b want=00", b0.lk_hist);
    end
    total_n++;
    if (tot0 !== 19 || cor0 !== 14 || mis0 !== 5 ||
        tot0 !== cor0 + mis0) begin
      bad_n++;
      $display("FAIL final_stats tot=%0d cor=%0d mis=%0d want 19/14/5",
               tot0, cor0, mis0);
    end
  endtask

  task automatic test_gshare();
    int n;
    total_n++;
    if (ready1 !== 1'b1) begin
      bad_n++;
      $display("FAIL gs_ready got=%b want=1", ready1);
    end
    b1.up_pc = 32'h4; b1.up_hist = 2'b11; b1.up_taken = 1'b1;
    b1.up_target = 32'h77; b1.up_mispred = 1'b1; b1.up_valid = 1'b1;
    @(posedge clk); #1;
    b1.up_valid = 1'b0;
    b1.lk_pc = 32'h4; #1;
    total_n++;
    if (b1.lk_taken !== 1'b1 || b1.lk_target !== 32'h77 ||
        b1.lk_hist !== 2'b11) begin
      bad_n++;
      $display("FAIL gs_hit taken=%b tgt=%h hist=%b want 1/77/11",
               b1.lk_taken, b1.lk_target, b1.lk_hist);
    end
    total_n++;
    if (tot1 !== 1 || mis1 !== 1) begin
      bad_n++;
      $display("FAIL gs_stats tot=%0d mis=%0d want 1/1", tot1, mis1);
    end
    @(posedge clk); #3;
    rstn1 = 1'b0;
    #1;
    total_n++;
    if (ready1 !== 1'b0 || tot1 !== 0 || mis1 !== 0 || cor1 !== 0 ||
        b1.lk_hist !== 2'b00 || b1.lk_taken !== 1'b0) begin
      bad_n++;
      $display("FAIL gs_async_reset ready=%b tot=%0d hist=%b tk=%b want 0",
               ready1, tot1, b1.lk_hist, b1.lk_taken);
    end
    @(negedge clk);
    rstn1 = 1'b1;
    n = 0;
    while (n < 2000) begin
      @(posedge clk); #1;
      n++;
      if (ready1 === 1'b1) break;
    end
    total_n++;
    if (n !== 1024) begin
      bad_n++;
      $display("FAIL gs_reinit got=%0d want=1024", n);
    end
  endtask

  initial begin
    b0.lk_valid = 1'b0; b0.lk_pc = '0; b0.up_valid = 1'b0;
    b0.up_pc = '0; b0.up_hist = '0; b0.up_taken = 1'b0;
    b0.up_target = '0; b0.up_mispred = 1'b0;
    b1.lk_valid = 1'b0; b1.lk_pc = '0; b1.up_valid = 1'b0;
    b1.up_pc = '0; b1.up_hist = '0; b1.up_taken = 1'b0;
    b1.up_target = '0; b1.up_mispred = 1'b0;
    #12;
    test_reset();
    test_training();
    test_saturation();
    test_tag_alias();
    test_same_cycle();
    test_back_to_back();
    test_recovery();
    test_gshare();
    $display("test done: total=%0d bad=%0d", total_n, bad_n);
    $finish;
  end
endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
Parametrised two-level adaptive branch predictor, extracted from the core into a standalone block. It provides a global history register (GHR), a pattern history table (PHT) of saturating counters and a tagged branch target buffer (BTB). Index mode is selectable: concatenated, or gshare (XOR). The GHR is shifted speculatively at fetch and repaired on mispredict. Fetch queries it combinationally; the execute stage returns resolved outcomes through an update port.

Parameters:
ADDR_W, 32, PC width (word-addressed; sequential next PC = pc+1)
INDEX_W, 8, PC bits used for the BTB index and the PHT index base
HIST_W, 2, global history length (>=1)
CTR_W, 2, PHT counter width (>=1)
CTR_INIT, 1, counter value after init sweep (weakly not-taken)
MODE, 0, 0 = concat index {pc[INDEX_W-1:0], hist}; 1 = gshare index pc[INDEX_W+HIST_W-1:0] ^ {INDEX_W'b0, hist}

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
ready  out  1  high once the init sweep has finished
lk_valid  in  1  fetch presents a branch/jump to predict (also triggers speculative GHR shift)
lk_pc  in  ADDR_W  fetch PC
lk_taken  out  1  predicted direction
lk_target  out  ADDR_W  predicted next PC
lk_hist  out  HIST_W  GHR snapshot used for this prediction, carried down the pipeline
up_valid  in  1  resolved branch from execute
up_pc  in  ADDR_W  PC of the resolved branch
up_hist  in  HIST_W  lk_hist carried with that branch
up_taken  in  1  actual direction
up_target  in  ADDR_W  actual destination
up_mispred  in  1  execute's jump_dest differed from the fetched next PC
stat_total  out  32  resolved branches
stat_correct  out  32  correctly predicted branches
stat_mispred  out  32  mispredicted branches

Behaviour:
- Async reset (rstn=0): GHR=0, all stat counters=0, ready=0, sweep pointer=0, FSM in INIT. Table arrays are not reset directly.
- FSM INIT: each cycle writes PHT[ptr]=CTR_INIT. While ptr<2^INDEX_W it also clears BTB[ptr].valid. The FSM stays in INIT for exactly 2^(INDEX_W+HIST_W) cycles, then goes to RUN with ready=1.
- In INIT, lk_taken=0 and lk_target=lk_pc+1. lk_valid and up_valid are ignored; the GHR and stats stay unchanged.
- Reset asserted mid-sweep or in RUN restarts INIT from ptr=0.
- Lookup (RUN) is purely combinational from the current tables and GHR, with zero latency:
  - PHT index is per MODE, using the current GHR. BTB index is lk_pc[INDEX_W-1:0]; the tag is lk_pc[ADDR_W-1:INDEX_W].
  - lk_taken = PHT MSB && BTB valid && tag match.
  - lk_target = lk_taken ? BTB target : lk_pc+1 (wraps modulo 2^ADDR_W).
  - lk_hist = current GHR, whether or not lk_valid is asserted.
- Speculative history: on a clock edge with lk_valid && no recovery, GHR <= {GHR[HIST_W-2:0], lk_taken}. When HIST_W=1, GHR <= lk_taken.
- Update (RUN, up_valid), at the clock edge:
  - PHT entry indexed by up_pc and up_hist (not the current GHR): saturating +1 if up_taken, -1 otherwise. It saturates at 2^CTR_W-1 and 0.
  - If up_taken: BTB[up_pc idx] <= {valid=1, up_pc tag, up_target}. Not-taken never modifies the BTB.
  - stat_total +1. Then stat_mispred +1 if up_mispred, else stat_correct +1. All stat counters wrap at 2^32.
  - If up_mispred, recovery: GHR <= {up_hist[HIST_W-2:0], up_taken}. This overrides any same-cycle speculative shift.
- Same-cycle lookup and update to the same entry: the lookup sees the pre-update contents; the write lands at the edge.
- Back-to-back updates to the same PHT entry on consecutive cycles must accumulate (no lost update).
- Invariant: in RUN, stat_total == stat_correct + stat_mispred.

Test Plan:
- Init: release rstn, defaults -> ready=0 for exactly 1024 cycles, then 1. Any lk_pc gives lk_taken=0, lk_target=lk_pc+1. up_valid pulsed during INIT leaves stat_total=0.
- Training: up_valid with up_pc=0x40, up_hist=0, up_taken=1, up_target=0x10, up_mispred=1, repeated twice (MODE 0) -> then, with GHR forced 0 via recovery, lk_pc=0x40 gives lk_taken=1, lk_target=0x10. stat_mispred=2, stat_total=2.
- Saturation: five taken updates then one not-taken on one entry -> counter is 3 after the taken updates and 2 after the not-taken, so the prediction stays taken. From 0, a not-taken update keeps it at 0.
- Tag alias: train 0x40 taken, look up 0x140 with the same PHT index -> lk_taken=0, lk_target=0x141.
- Recovery vs speculation: GHR=2'b11, lk_valid with lk_taken=0 plus same-cycle up_mispred with up_hist=2'b01, up_taken=0 -> GHR=2'b10 next cycle.
- MODE=1 gshare: up_pc=0x4, up_hist=2'b11 trains PHT index 0x7. Then a lookup of pc 0x4 with GHR=2'b11 uses that counter (verified by directed BTB hit). Async reset mid-run -> GHR=0, stats=0, ready drops.
